// File: rtl/memory_controller_pipe_if.sv
// BRAM-side bus of the memory controller pipe.
// master: controller (en/we/addr/din out, dout in); slave: BRAM.
interface memory_controller_pipe_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    modport master (
        output bram_en,
        output bram_we,
        output bram_addr,
        output bram_din,
        input  bram_dout
    );

    modport slave (
        input  bram_en,
        input  bram_we,
        input  bram_addr,
        input  bram_din,
        output bram_dout
    );
endinterface

// File: rtl/memory_controller_pipe.sv
// A/D/M register file with M backed by a pipelined BRAM read.
// Ports: clk, rst (async high), reg_{a,d,m}_en + data_in write strobes,
// reg_{a,d,m}_out values, m_valid, stall, bram (master modport).
module memory_controller_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reg_a_en,
    input  logic                      reg_d_en,
    input  logic                      reg_m_en,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W-1:0]         reg_a_out,
    output logic [DATA_W-1:0]         reg_d_out,
    output logic [DATA_W-1:0]         reg_m_out,
    output logic                      m_valid,
    output logic                      stall,
    memory_controller_pipe_if.master  bram
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        CAPTURE
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t      state;
    logic [1:0]  cnt;

    logic [ADDR_W-1:0] a_lo;
    logic [ADDR_W-1:0] new_lo;
    logic              same_addr;

    // Only the low ADDR_W bits of A select a BRAM word, so the
    // forwarding compare ignores the upper bits as well.
    assign a_lo      = reg_a_out[ADDR_W-1:0];
    assign new_lo    = data_in[ADDR_W-1:0];
    assign same_addr = (new_lo == a_lo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            reg_a_out      <= '0;
            reg_d_out      <= '0;
            reg_m_out      <= '0;
            m_valid        <= 1'b0;
            stall          <= 1'b0;
            bram.bram_en   <= 1'b0;
            bram.bram_we   <= 1'b0;
            bram.bram_addr <= '0;
            bram.bram_din  <= '0;
        end else begin
            // Enables are single-cycle pulses unless re-armed below.
            bram.bram_en <= 1'b0;
            bram.bram_we <= 1'b0;

            if (reg_d_en) begin
                reg_d_out <= data_in;
            end

            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        // M write to the current A, then reload A.
                        // Same word: the written value is already
                        // the new M, so no read is needed.
                        (reg_m_en && reg_a_en && same_addr): begin
                            bram.bram_en   <= 1'b1;
                            bram.bram_we   <= 1'b1;
                            bram.bram_addr <= a_lo;
                            bram.bram_din  <= data_in;
                            reg_m_out      <= data_in;
                            reg_a_out      <= data_in;
                            m_valid        <= 1'b1;
                        end
                        // Different word: the write occupies the
                        // BRAM this cycle, the read follows.
                        (reg_m_en && reg_a_en && !same_addr): begin
                            bram.bram_en   <= 1'b1;
                            bram.bram_we   <= 1'b1;
                            bram.bram_addr <= a_lo;
                            bram.bram_din  <= data_in;
                            reg_m_out      <= data_in;
                            reg_a_out      <= data_in;
                            m_valid        <= 1'b0;
                            stall          <= 1'b1;
                            state          <= RD_ISSUE;
                        end
                        (reg_m_en && !reg_a_en): begin
                            bram.bram_en   <= 1'b1;
                            bram.bram_we   <= 1'b1;
                            bram.bram_addr <= a_lo;
                            bram.bram_din  <= data_in;
                            reg_m_out      <= data_in;
                        end
                        // A-only: the read is issued on this edge.
                        (reg_a_en && !reg_m_en): begin
                            bram.bram_en   <= 1'b1;
                            bram.bram_addr <= new_lo;
                            reg_a_out      <= data_in;
                            m_valid        <= 1'b0;
                            stall          <= 1'b1;
                            cnt            <= CNT_INIT;
                            state          <= RD_WAIT;
                        end
                        default: begin
                        end
                    endcase
                end
                RD_ISSUE: begin
                    bram.bram_en   <= 1'b1;
                    bram.bram_addr <= a_lo;
                    cnt            <= CNT_INIT;
                    state          <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                CAPTURE: begin
                    reg_m_out <= bram.bram_dout;
                    m_valid   <= 1'b1;
                    stall     <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    stall <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
